// File: rtl/match_result_reader.sv
// match_result_reader: walks a wide weight-match bitmap CHUNK bits per cycle
// and streams out the index of every set bit in ascending order over a
// valid/ready handshake, then pulses done and reports how many were emitted.
module match_result_reader #(
  parameter  int WIDTH = 23331,
  parameter  int CHUNK = 16,
  localparam int IDXW  = $clog2(WIDTH),
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] result,
  output logic             res_ready,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_index,
  input  logic             out_ready,
  output logic [CNTW-1:0]  match_count,
  output logic             done,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  // Snapshot is padded to whole chunks; the pad bits are loaded as zero
  // and never set, so the last partial chunk reads zeros above WIDTH.
  localparam int TOTW   = NCHUNK * CHUNK;
  localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BITW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [TOTW-1:0]   r_snap;
  logic [PTRW-1:0]   r_ptr;
  logic              r_res_ready;
  logic              r_out_valid;
  logic [IDXW-1:0]   r_out_index;
  logic [CNTW-1:0]   r_match_count;
  logic              r_done;
  logic              r_busy;

  logic [31:0]       w_base;
  logic [CHUNK-1:0]  w_chunk;
  logic              w_hit;
  logic [BITW-1:0]   w_low;
  logic [31:0]       w_bitpos;
  logic [IDXW-1:0]   w_index;
  logic [TOTW-1:0]   w_clear_mask;

  assign w_base       = 32'(r_ptr) * 32'(CHUNK);
  assign w_chunk      = CHUNK'(r_snap >> w_base);
  assign w_hit        = |w_chunk;
  assign w_bitpos     = w_base + 32'(w_low);
  assign w_index      = IDXW'(w_bitpos);
  assign w_clear_mask = ~(TOTW'(1'b1) << w_bitpos);

  // Priority-encode the lowest set bit of the current chunk (descending
  // sweep so the last assignment wins with the smallest index).
  always_comb begin
    w_low = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      w_low = w_chunk[i] ? BITW'(i) : w_low;
    end
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_snap        <= '0;
      r_ptr         <= '0;
      r_res_ready   <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_index   <= '0;
      r_match_count <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (res_valid) begin
            r_snap        <= TOTW'(result);
            r_ptr         <= '0;
            r_match_count <= '0;
            r_res_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_SCAN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_out_index <= w_index;
            r_snap      <= r_snap & w_clear_mask;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (r_ptr == LAST_PTR) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr + PTRW'(1'b1);
          end
        end
        S_EMIT: begin
          // Index stays put until the consumer takes it; the pointer is
          // kept so the same chunk is rescanned for further set bits.
          if (out_ready) begin
            r_match_count <= r_match_count + CNTW'(1'b1);
            r_out_valid   <= 1'b0;
            r_state       <= S_SCAN;
          end else begin
            r_state <= S_EMIT;
          end
        end
        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_res_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_res_ready <= 1'b1;
        end
      endcase
    end
  end

  assign res_ready   = r_res_ready;
  assign out_valid   = r_out_valid;
  assign out_index   = r_out_index;
  assign match_count = r_match_count;
  assign done        = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_match_result_reader.sv
// Bench for match_result_reader (WIDTH=40, CHUNK=16): directed scenarios plus
// random vectors, checked every cycle against a queue-based reference model.
module tb_match_result_reader;

  localparam int WIDTH  = 40;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = 3;
  localparam int IDXW   = 6;
  localparam int CNTW   = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             res_valid = 1'b0;
  logic [WIDTH-1:0] result = '0;
  logic             out_ready = 1'b0;
  logic             res_ready;
  logic             out_valid;
  logic [IDXW-1:0]  out_index;
  logic [CNTW-1:0]  match_count;
  logic             done;
  logic             busy;

  match_result_reader #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .result(result),
    .res_ready(res_ready), .out_valid(out_valid), .out_index(out_index),
    .out_ready(out_ready), .match_count(match_count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int  q[$];
  int  got[$];
  bit  active = 1'b0;
  int  m = 0;
  int  ev = 0;
  int  acc_cyc = 0;
  int  cyc = 0;
  int  done_lat = 0;
  bit  prev_v = 1'b0;
  bit  prev_r = 1'b0;
  int  prev_idx = 0;
  int  rmode = 0;

  // Per-cycle comparison of DUT outputs against the model (inputs shown here
  // are the ones the next rising edge will sample).
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_match_count", match_count, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_ready", res_ready, 1);
      active = 1'b0;
      q.delete();
      m = 0;
      prev_v = 1'b0;
    end else begin
      chk("res_ready", res_ready, !active);
      chk("busy", busy, active);
      chk("match_count", match_count, m);
      if (prev_v && !prev_r) chk("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (!active || q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("out_index", out_index, q[0]);
          if (prev_v && !prev_r) chk("hold_index", out_index, prev_idx);
          ev++;
          if (out_ready) begin
            got.push_back(int'(out_index));
            void'(q.pop_front());
            m++;
          end
        end
      end
      if (done) begin
        if (!active) begin
          chk("spurious_done", done, 0);
        end else begin
          chk("done_cycle", cyc - acc_cyc, NCHUNK + m + ev + 1);
          chk("done_all_emitted", q.size(), 0);
          done_lat = cyc - acc_cyc;
          active = 1'b0;
        end
      end
      if (res_valid && !active) begin
        active = 1'b1;
        q.delete();
        for (int i = 0; i < WIDTH; i++) if (result[i]) q.push_back(i);
        m = 0;
        ev = 0;
        acc_cyc = cyc;
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_idx = int'(out_index);
    end
  end

  // Downstream ready: constant 1, random, or left to the directed sequence.
  always @(posedge clk) begin
    #2;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    int n = 0;
    while (!res_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("send_timeout", n, 0);
    res_valid = 1'b1;
    result = v;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("done_timeout", n, 0);
    tick();
  endtask

  function automatic int got_at(input int k);
    return (k < got.size()) ? got[k] : -1;
  endfunction

  initial begin
    int exp_b[4];
    int n;
    int n30;
    logic [WIDTH-1:0] v;
    int dens;
    exp_b = '{0, 15, 16, 39};

    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // (a) all-zero vector
    got.delete();
    send(40'h0);
    wait_done();
    chk("a_latency", done_lat, 4);
    chk("a_count", match_count, 0);
    chk("a_nidx", got.size(), 0);

    // (b) bits {0,15,16,39}
    got.delete();
    send(40'h80_0001_8001);
    wait_done();
    chk("b_count", match_count, 4);
    chk("b_nidx", got.size(), 4);
    for (int k = 0; k < 4; k++) chk("b_idx", got_at(k), exp_b[k]);
    chk("b_latency", done_lat, 12);

    // (c) bits {5,6}, ready held low for 3 cycles at first out_valid
    rmode = 2;
    out_ready = 1'b0;
    got.delete();
    send(40'h60);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("c_valid_timeout", n, 0);
    for (int k = 0; k < 3; k++) begin
      chk("c_hold_valid", out_valid, 1);
      chk("c_hold_idx", out_index, 5);
      tick();
    end
    out_ready = 1'b1;
    wait_done();
    chk("c_count", match_count, 2);
    chk("c_nidx", got.size(), 2);
    chk("c_idx0", got_at(0), 5);
    chk("c_idx1", got_at(1), 6);
    rmode = 0;

    // (d) second vector offered while busy is ignored
    got.delete();
    send(40'h10_0002);
    tick();
    tick();
    chk("d_busy", busy, 1);
    res_valid = 1'b1;
    result = 40'h80;
    tick();
    res_valid = 1'b0;
    wait_done();
    chk("d_nidx", got.size(), 2);
    chk("d_idx0", got_at(0), 1);
    chk("d_idx1", got_at(1), 20);
    got.delete();
    send(40'h80);
    wait_done();
    chk("d2_nidx", got.size(), 1);
    chk("d2_idx", got_at(0), 7);
    chk("d2_count", match_count, 1);

    // (e) every bit set
    got.delete();
    send({WIDTH{1'b1}});
    wait_done();
    chk("e_count", match_count, 40);
    chk("e_nidx", got.size(), 40);
    for (int k = 0; k < 40; k++) chk("e_idx", got_at(k), k);

    // (f) reset during EMIT of bit 16 of {3,16,30}
    got.delete();
    send(40'h00_4001_0008);
    n = 0;
    while (!(out_valid && out_index == 6'd16) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("f_emit_timeout", n, 0);
    #1 reset = 1'b0;
    #1;
    chk("f_async_out_valid", out_valid, 0);
    chk("f_async_busy", busy, 0);
    @(posedge clk);
    #2;
    tick();
    reset = 1'b1;
    chk("f_res_ready", res_ready, 1);
    repeat (60) tick();
    n30 = 0;
    foreach (got[k]) if (got[k] == 30) n30++;
    chk("f_no_idx30", n30, 0);
    chk("f_nidx", got.size(), 1);

    // Random vectors with random downstream back-pressure
    rmode = 1;
    for (int t = 0; t < 25; t++) begin
      dens = int'($urandom_range(0, 100));
      for (int i = 0; i < WIDTH; i++) v[i] = ($urandom_range(0, 99) < dens);
      send(v);
      wait_done();
      chk("r_count", match_count, $countones(v));
    end
    rmode = 0;
    repeat (3) tick();
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_result_reader.md
MATCH_RESULT_READER -- requirements
Module: match_result_reader

Interface
REQ-001: The block SHALL have parameter WIDTH, default 23331, the number of weight-match bits in one result vector.
REQ-002: The block SHALL have parameter CHUNK, default 16, the number of result bits examined per scan cycle.
REQ-003: The block SHALL have localparams IDXW = $clog2(WIDTH), CNTW = $clog2(WIDTH+1) and NCHUNK = ceil(WIDTH/CHUNK).
REQ-004: Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005: Port reset, input, 1, asynchronous active-low reset.
REQ-006: Port res_valid, input, 1, result vector available from the matcher.
REQ-007: Port result, input, WIDTH, match bitmap; bit i set means weight i matched.
REQ-008: Port res_ready, output, 1, block accepts a new result vector.
REQ-009: Port out_valid, output, 1, out_index holds a matched weight index.
REQ-010: Port out_index, output, IDXW, index of a set result bit.
REQ-011: Port out_ready, input, 1, downstream accepts out_index.
REQ-012: Port match_count, output, CNTW, number of indices emitted for the current or last vector.
REQ-013: Port done, output, 1, one-cycle pulse marking the end of a vector.
REQ-014: Port busy, output, 1, high in every state except IDLE.

Function
REQ-015: The block SHALL use the states IDLE, SCAN, EMIT and DONE.
REQ-016: In IDLE, res_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017: In IDLE with res_valid=1, the block SHALL copy result into an internal snapshot, clear the chunk pointer and match_count, and enter SCAN on the next cycle.
REQ-018: While res_ready=0, res_valid and result SHALL be ignored; no queuing.
REQ-019: In SCAN, the block SHALL examine snapshot bits [ptr*CHUNK +: CHUNK]; bits at or above WIDTH in the last chunk SHALL be treated as 0.
REQ-020: In SCAN, if the chunk is nonzero, the block SHALL:
- select the lowest set bit b;
- register out_index = ptr*CHUNK+b;
- clear that snapshot bit;
- assert out_valid;
- enter EMIT.
REQ-021: In SCAN, if the chunk is zero and ptr<NCHUNK-1, ptr SHALL increment and the block SHALL remain in SCAN.
REQ-022: In SCAN, if the chunk is zero and ptr=NCHUNK-1, the block SHALL enter DONE.
REQ-023: In EMIT, out_valid and out_index SHALL hold stable until out_valid&&out_ready.
REQ-024: On that handshake, match_count SHALL increment, out_valid SHALL drop on the next cycle, and the block SHALL return to SCAN with the same ptr.
REQ-025: Indices SHALL be emitted in strictly ascending order, each set bit exactly once.
REQ-026: Timing per vector SHALL be:
- one SCAN cycle per empty chunk;
- one SCAN cycle plus at least one EMIT cycle per match.
REQ-027: In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL enter IDLE.
REQ-028: match_count SHALL hold its final value until the next vector is accepted.
REQ-029: An all-zero vector SHALL produce no out_valid, match_count=0, and done exactly NCHUNK+1 cycles after acceptance.
REQ-030: out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031: reset=0 SHALL asynchronously force:
- state IDLE;
- out_valid=0, out_index=0, match_count=0, done=0, busy=0;
- snapshot and ptr cleared.
REQ-032: After reset, res_ready SHALL be 1.
REQ-033: Reset asserted mid-scan or mid-EMIT SHALL abandon the vector; no further indices from it SHALL appear after release.

Verification
REQ-034: The bench SHALL run with WIDTH=40 and CHUNK=16, and SHALL cover these scenarios:
- (a) result=0, out_ready=1 -> no out_valid; done 4 cycles after acceptance; match_count=0.
- (b) bits {0,15,16,39} set, out_ready=1 -> out_index 0,15,16,39 in order; match_count=4; one done pulse.
- (c) bits {5,6} set, out_ready low 3 cycles at first out_valid -> index 5 held stable 3 cycles; then 5,6 delivered once each; match_count=2.
- (d) res_valid pulsed with a new vector while busy -> ignored; only the first vector's indices emitted; second vector accepted after return to IDLE.
- (e) all 40 bits set -> 40 ascending indices 0..39; match_count=40.
- (f) reset asserted during EMIT of bit 16 of vector {3,16,30} -> out_valid=0 immediately; res_ready=1 after release; no index 30 emitted.
